// File: rtl/imem_loader.sv
// Length-prefixed byte-stream writer for the instruction memory; holds the CPU while loading.
// Optional trailing checksum byte is enabled by defining CHECKSUM_EN.
module imem_loader #(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 24,
    parameter int LEN_W     = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    output logic              MemWrEn,
    output logic [ADDR_W-1:0] MemWrAddr,
    output logic [7:0]        MemWrData,
    output logic              CpuHold,
    output logic              Done,
    output logic              Error,
    output logic [LEN_W-1:0]  BytesLoaded
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
`ifdef CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

    state_t           state;
    logic [7:0]       len_hi;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_in;
    logic             len_bad;
    logic             last_byte;
    logic             xfer;
`ifdef CHECKSUM_EN
    logic [7:0]       sum;
`endif

    always_comb begin
        xfer      = ByteValid & ByteReady;
        len_in    = LEN_W'({len_hi, ByteIn});
        len_bad   = (len_in > LEN_W'(MEM_BYTES)) || ((len_in % LEN_W'(3)) != '0);
        last_byte = (BytesLoaded + LEN_W'(1)) == len;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state       <= IDLE;
            len_hi      <= '0;
            len         <= '0;
            ByteReady   <= 1'b0;
            MemWrEn     <= 1'b0;
            MemWrAddr   <= '0;
            MemWrData   <= '0;
            CpuHold     <= 1'b0;
            Done        <= 1'b0;
            Error       <= 1'b0;
            BytesLoaded <= '0;
`ifdef CHECKSUM_EN
            sum         <= '0;
`endif
        end else begin
            MemWrEn <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (Start) begin
                        state       <= LEN_HI;
                        ByteReady   <= 1'b1;
                        CpuHold     <= 1'b1;
                        Done        <= 1'b0;
                        Error       <= 1'b0;
                        BytesLoaded <= '0;
                        MemWrAddr   <= '0;
`ifdef CHECKSUM_EN
                        sum         <= '0;
`endif
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_hi <= ByteIn;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len <= len_in;
                        if (len_bad) begin
                            state     <= ERR;
                            ByteReady <= 1'b0;
                            Error     <= 1'b1;
                        end else if (len_in == '0) begin
`ifdef CHECKSUM_EN
                            state     <= CHK;
`else
                            state     <= DONE;
                            ByteReady <= 1'b0;
                            CpuHold   <= 1'b0;
                            Done      <= 1'b1;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        MemWrEn     <= 1'b1;
                        MemWrData   <= ByteIn;
                        MemWrAddr   <= ADDR_W'(BytesLoaded);
                        BytesLoaded <= BytesLoaded + LEN_W'(1);
`ifdef CHECKSUM_EN
                        sum <= sum + ByteIn;
                        if (last_byte) state <= CHK;
`else
                        // Done and released hold coincide with the final write strobe.
                        if (last_byte) begin
                            state     <= DONE;
                            ByteReady <= 1'b0;
                            CpuHold   <= 1'b0;
                            Done      <= 1'b1;
                        end
`endif
                    end
                end
`ifdef CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        ByteReady <= 1'b0;
                        if (ByteIn == sum) begin
                            state   <= DONE;
                            CpuHold <= 1'b0;
                            Done    <= 1'b1;
                        end else begin
                            state <= ERR;
                            Error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    ByteReady <= 1'b0;
                    CpuHold   <= 1'b0;
                end
            endcase
        end
    end

endmodule
